// File: rtl/dcache_pkg.sv
// Shared types and sizing for the dcache line fill/writeback sequencer.
package dcache_pkg;

    localparam int unsigned DATABITS      = 32;
    localparam int unsigned CACHEADDRBITS = 5;
    localparam int unsigned LINEBITS      = 3;
    localparam int unsigned MEMADDRBITS   = 30;
    localparam int unsigned LINEIDXBITS   = CACHEADDRBITS - LINEBITS;
    localparam int unsigned LINEWORDS     = 2 ** LINEBITS;
    localparam int unsigned WATCHDOG_MAX  = 255;
    localparam int unsigned WDBITS        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_RD,
        ST_WB_CAP,
        ST_WB_WR,
        ST_FILL_REQ,
        ST_FILL_DATA,
        ST_DONE
    } state_e;

    // Cache word address of word k within a line.
    function automatic logic [CACHEADDRBITS-1:0] word_addr(
        input logic [LINEIDXBITS-1:0] line,
        input logic [LINEBITS-1:0]    k
    );
        return {line, k};
    endfunction

endpackage

// File: rtl/dcache_line_ctrl_if.sv
// Main-memory request/response bus between the line sequencer and memory.
interface dcache_line_ctrl_if;
    import dcache_pkg::*;

    logic [MEMADDRBITS-1:0] mem_addr;
    logic                   mem_rdreq;
    logic                   mem_wrreq;
    logic [DATABITS-1:0]    mem_wdata;
    logic                   mem_ack;
    logic [DATABITS-1:0]    mem_rdata;
    logic                   mem_rdata_valid;

    modport master (
        output mem_addr, mem_rdreq, mem_wrreq, mem_wdata,
        input  mem_ack, mem_rdata, mem_rdata_valid
    );

    modport slave (
        input  mem_addr, mem_rdreq, mem_wrreq, mem_wdata,
        output mem_ack, mem_rdata, mem_rdata_valid
    );

endinterface

// File: rtl/dcache_line_ctrl.sv
// Cache-miss line sequencer: dirty-victim writeback, then burst line fill.
// Optional fill watchdog (fill_error output) enabled by DCACHE_FILL_WATCHDOG_EN.
module dcache_line_ctrl
    import dcache_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     miss_req,
    input  logic [LINEIDXBITS-1:0]   miss_line,
    input  logic [MEMADDRBITS-1:0]   miss_mem_addr,
    input  logic                     victim_dirty,
    input  logic [MEMADDRBITS-1:0]   victim_mem_addr,
    output logic                     miss_ack,
    output logic                     busy,
    output logic                     flush_mode,
    output logic [CACHEADDRBITS-1:0] flush_addr,
    output logic                     flush_write,
    output logic [DATABITS-1:0]      line_in,
    output logic                     line_in_valid,
    input  logic [DATABITS-1:0]      cache_rdata,
    dcache_line_ctrl_if.master       mem
`ifdef DCACHE_FILL_WATCHDOG_EN
    ,
    output logic                     fill_error
`endif
);

    localparam logic [LINEBITS-1:0] K_LAST = LINEBITS'(LINEWORDS - 1);

    state_e                   state_q, state_d;
    logic [LINEBITS-1:0]      k_q, k_d;
    logic [LINEIDXBITS-1:0]   line_q, line_d;
    logic [MEMADDRBITS-1:0]   miss_addr_q, miss_addr_d;
    logic [MEMADDRBITS-1:0]   victim_addr_q, victim_addr_d;
    logic [DATABITS-1:0]      mem_wdata_q, mem_wdata_d;
    logic [MEMADDRBITS-1:0]   mem_addr_q, mem_addr_d;
    logic                     mem_rdreq_q, mem_rdreq_d;
    logic                     mem_wrreq_q, mem_wrreq_d;
    logic                     miss_ack_q, miss_ack_d;
    logic                     busy_q, busy_d;
    logic                     flush_mode_q, flush_mode_d;
    logic                     in_fill;
    logic                     beat_ok;

`ifdef DCACHE_FILL_WATCHDOG_EN
    logic [WDBITS-1:0]        wd_q, wd_d;
    logic                     fill_error_q, fill_error_d;
`endif

    assign in_fill = (state_q == ST_FILL_REQ) || (state_q == ST_FILL_DATA);
    assign beat_ok = in_fill && mem.mem_rdata_valid;

    // Next-state, counter, latched fields and registered-output next values.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        line_d        = line_q;
        miss_addr_d   = miss_addr_q;
        victim_addr_d = victim_addr_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (miss_req) begin
                    line_d        = miss_line;
                    miss_addr_d   = miss_mem_addr;
                    victim_addr_d = victim_mem_addr;
                    k_d           = '0;
                    state_d       = victim_dirty ? ST_WB_RD : ST_FILL_REQ;
                end
            end
            ST_WB_RD:  state_d = ST_WB_CAP;
            ST_WB_CAP: begin
                mem_wdata_d = cache_rdata;
                state_d     = ST_WB_WR;
            end
            ST_WB_WR: begin
                if (mem.mem_ack) begin
                    k_d     = (k_q == K_LAST) ? '0 : LINEBITS'(k_q + 1'b1);
                    state_d = (k_q == K_LAST) ? ST_FILL_REQ : ST_WB_RD;
                end
            end
            ST_FILL_REQ: begin
                if (mem.mem_ack) state_d = ST_FILL_DATA;
                // A completed burst wins over a still-pending request ack.
                if (beat_ok) begin
                    k_d = LINEBITS'(k_q + 1'b1);
                    if (k_q == K_LAST) state_d = ST_DONE;
                end
            end
            ST_FILL_DATA: begin
                if (beat_ok) begin
                    k_d = LINEBITS'(k_q + 1'b1);
                    if (k_q == K_LAST) state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

`ifdef DCACHE_FILL_WATCHDOG_EN
        wd_d         = '0;
        fill_error_d = 1'b0;
        if (!(mem.mem_ack || mem.mem_rdata_valid) && in_fill) begin
            wd_d = WDBITS'(wd_q + 1'b1);
            if (wd_d == WDBITS'(WATCHDOG_MAX)) begin
                wd_d         = '0;
                fill_error_d = 1'b1;
                state_d      = ST_IDLE;
            end
        end
`endif

        busy_d       = (state_d != ST_IDLE);
        flush_mode_d = (state_d != ST_IDLE);
        miss_ack_d   = (state_d == ST_DONE);
        mem_rdreq_d  = (state_d == ST_FILL_REQ);
        mem_wrreq_d  = (state_d == ST_WB_WR);
        case (state_d)
            ST_WB_WR:    mem_addr_d = victim_addr_d + MEMADDRBITS'(k_d);
            ST_FILL_REQ: mem_addr_d = miss_addr_d;
            default:     mem_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            line_q        <= '0;
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            mem_wdata_q   <= '0;
            mem_addr_q    <= '0;
            mem_rdreq_q   <= 1'b0;
            mem_wrreq_q   <= 1'b0;
            miss_ack_q    <= 1'b0;
            busy_q        <= 1'b0;
            flush_mode_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            line_q        <= line_d;
            miss_addr_q   <= miss_addr_d;
            victim_addr_q <= victim_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_rdreq_q   <= mem_rdreq_d;
            mem_wrreq_q   <= mem_wrreq_d;
            miss_ack_q    <= miss_ack_d;
            busy_q        <= busy_d;
            flush_mode_q  <= flush_mode_d;
        end
    end

`ifdef DCACHE_FILL_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q         <= '0;
            fill_error_q <= 1'b0;
        end else begin
            wd_q         <= wd_d;
            fill_error_q <= fill_error_d;
        end
    end

    assign fill_error = fill_error_q;
`endif

    // Memblock port: writeback read address, or fill beat written through same cycle.
    always_comb begin
        flush_addr    = '0;
        flush_write   = 1'b0;
        line_in       = '0;
        line_in_valid = 1'b0;
        if (state_q == ST_WB_RD) begin
            flush_addr = word_addr(line_q, k_q);
        end
        if (beat_ok) begin
            flush_addr    = word_addr(line_q, k_q);
            flush_write   = 1'b1;
            line_in       = mem.mem_rdata;
            line_in_valid = 1'b1;
        end
    end

    assign miss_ack      = miss_ack_q;
    assign busy          = busy_q;
    assign flush_mode    = flush_mode_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_rdreq = mem_rdreq_q;
    assign mem.mem_wrreq = mem_wrreq_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_line_ctrl.sv
// Directed bench for dcache_line_ctrl with a small memblock model on the flush port.
module tb_dcache_line_ctrl;
    import dcache_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     miss_req;
    logic [LINEIDXBITS-1:0]   miss_line;
    logic [MEMADDRBITS-1:0]   miss_mem_addr;
    logic                     victim_dirty;
    logic [MEMADDRBITS-1:0]   victim_mem_addr;
    logic                     miss_ack;
    logic                     busy;
    logic                     flush_mode;
    logic [CACHEADDRBITS-1:0] flush_addr;
    logic                     flush_write;
    logic [DATABITS-1:0]      line_in;
    logic                     line_in_valid;
    logic [DATABITS-1:0]      cache_rdata;
`ifdef DCACHE_FILL_WATCHDOG_EN
    logic                     fill_error;
`endif

    dcache_line_ctrl_if mem_if ();

    dcache_line_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .miss_req        (miss_req),
        .miss_line       (miss_line),
        .miss_mem_addr   (miss_mem_addr),
        .victim_dirty    (victim_dirty),
        .victim_mem_addr (victim_mem_addr),
        .miss_ack        (miss_ack),
        .busy            (busy),
        .flush_mode      (flush_mode),
        .flush_addr      (flush_addr),
        .flush_write     (flush_write),
        .line_in         (line_in),
        .line_in_valid   (line_in_valid),
        .cache_rdata     (cache_rdata),
        .mem             (mem_if)
`ifdef DCACHE_FILL_WATCHDOG_EN
        ,
        .fill_error      (fill_error)
`endif
    );

    always #5 clk = ~clk;

    // Memblock model: write-through on flush_write, registered read data.
    logic [DATABITS-1:0] cmem [0:31];
    logic                pre_we;
    logic [4:0]          pre_addr;
    logic [DATABITS-1:0] pre_data;
    always @(posedge clk) begin
        if (pre_we) cmem[pre_addr] <= pre_data;
        else if (flush_write) cmem[flush_addr] <= line_in;
        cache_rdata <= cmem[flush_addr];
    end

    int ack_cnt  = 0;
    int wack_cnt = 0;
    always @(posedge clk) begin
        if (miss_ack) ack_cnt <= ack_cnt + 1;
        if (mem_if.mem_wrreq && mem_if.mem_ack) wack_cnt <= wack_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_beats(input int line, input logic [DATABITS-1:0] d0);
        for (int i = 0; i < 8; i++) begin
            mem_if.mem_rdata_valid = 1'b1;
            mem_if.mem_rdata       = d0 + 32'(i);
            #1;
            chk("beat_we",   64'(flush_write), 64'(1));
            chk("beat_addr", 64'(flush_addr),  64'(line * 8 + i));
            chk("beat_data", 64'(line_in),     64'(d0 + 32'(i)));
            tick();
        end
        mem_if.mem_rdata_valid = 1'b0;
        mem_if.mem_rdata       = '0;
    endtask

    task automatic check_line(input int line, input logic [DATABITS-1:0] d0);
        for (int i = 0; i < 8; i++)
            chk("line_mem", 64'(cmem[line * 8 + i]), 64'(d0 + 32'(i)));
    endtask

    // Enters in WB_RD cycle; leaves at the cycle after the acked WB_WR.
    task automatic wb_word(input int line, input int k, input int stall,
                           input logic [MEMADDRBITS-1:0] exp_addr,
                           input logic [DATABITS-1:0] exp_data);
        #1;
        chk("wb_rd_addr", 64'(flush_addr),        64'(line * 8 + k));
        chk("wb_rd_we",   64'(flush_write),       64'(0));
        chk("wb_rd_req",  64'(mem_if.mem_wrreq),  64'(0));
        tick();
        tick();
        for (int s = 0; s < stall; s++) begin
            #1;
            chk("wb_stall_req",  64'(mem_if.mem_wrreq), 64'(1));
            chk("wb_stall_addr", 64'(mem_if.mem_addr),  64'(exp_addr));
            chk("wb_stall_data", 64'(mem_if.mem_wdata), 64'(exp_data));
            tick();
        end
        mem_if.mem_ack = 1'b1;
        #1;
        chk("wb_req",  64'(mem_if.mem_wrreq), 64'(1));
        chk("wb_addr", 64'(mem_if.mem_addr),  64'(exp_addr));
        chk("wb_data", 64'(mem_if.mem_wdata), 64'(exp_data));
        tick();
        mem_if.mem_ack = 1'b0;
    endtask

    // Clean miss with immediate ack and back-to-back beats; entered at request cycle.
    task automatic clean_miss(input int line, input logic [MEMADDRBITS-1:0] addr,
                              input logic [DATABITS-1:0] d0);
        miss_req      = 1'b1;
        miss_line     = LINEIDXBITS'(line);
        miss_mem_addr = addr;
        victim_dirty  = 1'b0;
        tick();
        miss_req       = 1'b0;
        mem_ack_set(1'b1);
        #1;
        chk("cm_rdreq", 64'(mem_if.mem_rdreq), 64'(1));
        chk("cm_addr",  64'(mem_if.mem_addr),  64'(addr));
        tick();
        mem_ack_set(1'b0);
        fill_beats(line, d0);
        #1;
        chk("cm_ack", 64'(miss_ack), 64'(1));
        tick();
        #1;
        chk("cm_idle", 64'(busy), 64'(0));
    endtask

    task automatic mem_ack_set(input logic v);
        mem_if.mem_ack = v;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [MEMADDRBITS-1:0] wrap_base;
        reset                  = 1'b1;
        miss_req               = 1'b0;
        miss_line              = '0;
        miss_mem_addr          = '0;
        victim_dirty           = 1'b0;
        victim_mem_addr        = '0;
        mem_if.mem_ack         = 1'b0;
        mem_if.mem_rdata       = '0;
        mem_if.mem_rdata_valid = 1'b0;
        pre_we                 = 1'b0;
        pre_addr               = '0;
        pre_data               = '0;

        // Preload victim line 1 (words 8..15) during reset.
        for (int i = 0; i < 8; i++) begin
            pre_we   = 1'b1;
            pre_addr = 5'(8 + i);
            pre_data = 32'h11 + 32'(i);
            tick();
        end
        pre_we = 1'b0;
        tick();
        #1;
        chk("rst_busy",   64'(busy),              64'(0));
        chk("rst_fmode",  64'(flush_mode),        64'(0));
        chk("rst_ack",    64'(miss_ack),          64'(0));
        chk("rst_rdreq",  64'(mem_if.mem_rdreq),  64'(0));
        chk("rst_wrreq",  64'(mem_if.mem_wrreq),  64'(0));
        chk("rst_maddr",  64'(mem_if.mem_addr),   64'(0));
        chk("rst_wdata",  64'(mem_if.mem_wdata),  64'(0));
        chk("rst_fwe",    64'(flush_write),       64'(0));
        chk("rst_faddr",  64'(flush_addr),        64'(0));
        chk("rst_lvalid", 64'(line_in_valid),     64'(0));
        tick();
        reset = 1'b0;

        // Beat while idle must not reach the memblock.
        mem_if.mem_rdata_valid = 1'b1;
        mem_if.mem_rdata       = 32'hDEAD;
        #1;
        chk("idle_beat_we", 64'(flush_write),   64'(0));
        chk("idle_beat_lv", 64'(line_in_valid), 64'(0));
        tick();
        mem_if.mem_rdata_valid = 1'b0;

        // Clean miss, line 2, request held high through DONE; miss_ack on cycle 10.
        miss_req        = 1'b1;
        miss_line       = 2'd2;
        miss_mem_addr   = 30'h100;
        victim_dirty    = 1'b0;
        victim_mem_addr = 30'h3FF;
        #1;
        chk("t1_c0_busy", 64'(busy), 64'(0));
        tick();
        mem_if.mem_ack = 1'b1;
        #1;
        chk("t1_busy",  64'(busy),              64'(1));
        chk("t1_fmode", 64'(flush_mode),        64'(1));
        chk("t1_rdreq", 64'(mem_if.mem_rdreq),  64'(1));
        chk("t1_addr",  64'(mem_if.mem_addr),   64'(30'h100));
        chk("t1_wrreq", 64'(mem_if.mem_wrreq),  64'(0));
        tick();
        mem_if.mem_ack = 1'b0;
        #1;
        chk("t1_rdreq_drop", 64'(mem_if.mem_rdreq), 64'(0));
        fill_beats(2, 32'hA0);
        #1;
        chk("t1_ack",      64'(miss_ack), 64'(1));
        chk("t1_done_bsy", 64'(busy),     64'(1));
        tick();
        miss_req = 1'b0;
        #1;
        chk("t1_ack_pulse", 64'(miss_ack), 64'(0));
        chk("t1_idle",      64'(busy),     64'(0));
        chk("t1_fm_idle",   64'(flush_mode), 64'(0));
        tick();
        #1;
        chk("t1_no_retrig", 64'(busy), 64'(0));
        chk("t1_ack_cnt",   64'(ack_cnt),  64'(1));
        chk("t1_no_writes", 64'(wack_cnt), 64'(0));
        check_line(2, 32'hA0);

        // Dirty miss, line 1, writeback to 0x40.., then fill from 0x200.
        tick();
        miss_req        = 1'b1;
        miss_line       = 2'd1;
        victim_dirty    = 1'b1;
        victim_mem_addr = 30'h40;
        miss_mem_addr   = 30'h200;
        tick();
        miss_req = 1'b0;
        for (int k = 0; k < 8; k++)
            wb_word(1, k, 0, 30'h40 + 30'(k), 32'h11 + 32'(k));
        mem_if.mem_ack = 1'b1;
        #1;
        chk("t2_rdreq", 64'(mem_if.mem_rdreq), 64'(1));
        chk("t2_addr",  64'(mem_if.mem_addr),  64'(30'h200));
        chk("t2_wrreq", 64'(mem_if.mem_wrreq), 64'(0));
        tick();
        mem_if.mem_ack = 1'b0;
        fill_beats(1, 32'h31);
        #1;
        chk("t2_ack", 64'(miss_ack), 64'(1));
        tick();
        #1;
        chk("t2_idle",   64'(busy),     64'(0));
        chk("t2_writes", 64'(wack_cnt), 64'(8));
        check_line(1, 32'h31);

        // Dirty miss with 3-cycle write stalls and a victim address that wraps.
        tick();
        wrap_base       = 30'h3FFF_FFFC;
        miss_req        = 1'b1;
        miss_line       = 2'd1;
        victim_dirty    = 1'b1;
        victim_mem_addr = wrap_base;
        miss_mem_addr   = 30'h280;
        tick();
        miss_req = 1'b0;
        for (int k = 0; k < 8; k++)
            wb_word(1, k, 3, wrap_base + 30'(k), 32'h31 + 32'(k));
        mem_if.mem_ack = 1'b1;
        #1;
        chk("t3_addr", 64'(mem_if.mem_addr), 64'(30'h280));
        tick();
        mem_if.mem_ack = 1'b0;
        fill_beats(1, 32'h51);
        #1;
        chk("t3_ack", 64'(miss_ack), 64'(1));
        tick();
        #1;
        chk("t3_writes", 64'(wack_cnt), 64'(16));
        check_line(1, 32'h51);

        // All beats arrive before the request ack; the late ack is ignored.
        tick();
        miss_req      = 1'b1;
        miss_line     = 2'd3;
        miss_mem_addr = 30'h300;
        victim_dirty  = 1'b0;
        tick();
        miss_req = 1'b0;
        #1;
        chk("t4_rdreq", 64'(mem_if.mem_rdreq), 64'(1));
        chk("t4_addr",  64'(mem_if.mem_addr),  64'(30'h300));
        fill_beats(3, 32'hC0);
        mem_if.mem_ack = 1'b1;
        #1;
        chk("t4_ack",       64'(miss_ack),         64'(1));
        chk("t4_rdreq_off", 64'(mem_if.mem_rdreq), 64'(0));
        tick();
        #1;
        chk("t4_idle",      64'(busy),     64'(0));
        chk("t4_ack_pulse", 64'(miss_ack), 64'(0));
        tick();
        mem_if.mem_ack = 1'b0;
        #1;
        chk("t4_still_idle", 64'(busy),    64'(0));
        chk("t4_ack_cnt",    64'(ack_cnt), 64'(4));
        check_line(3, 32'hC0);

        // Reset during FILL_DATA with k=4 aborts with no miss_ack.
        tick();
        miss_req      = 1'b1;
        miss_line     = 2'd0;
        miss_mem_addr = 30'h500;
        victim_dirty  = 1'b0;
        tick();
        miss_req       = 1'b0;
        mem_if.mem_ack = 1'b1;
        tick();
        mem_if.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_if.mem_rdata_valid = 1'b1;
            mem_if.mem_rdata       = 32'hE0 + 32'(i);
            tick();
        end
        mem_if.mem_rdata_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_pre_busy", 64'(busy), 64'(1));
        tick();
        reset = 1'b0;
        #1;
        chk("t5_busy",  64'(busy),             64'(0));
        chk("t5_fmode", 64'(flush_mode),       64'(0));
        chk("t5_rdreq", 64'(mem_if.mem_rdreq), 64'(0));
        chk("t5_ack",   64'(miss_ack),         64'(0));
        chk("t5_fwe",   64'(flush_write),      64'(0));
        tick();
        tick();
        #1;
        chk("t5_ack_cnt", 64'(ack_cnt), 64'(4));

        // Following clean miss completes normally.
        tick();
        clean_miss(0, 30'h600, 32'hF0);
        chk("t6_ack_cnt", 64'(ack_cnt), 64'(5));
        check_line(0, 32'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
